tl45_dprf: RTL
==============

// Module: tl45_dprf
// PURPOSE
//  Dual-read, single-write 32-bit register file with pending-write scoreboard for the TL45 core.
//  Serves the register-read stage: combinational reads, busy marking of the issuing DR, busy list.
//  Accepts writeback from the end of the pipe. r0 reads as zero, is never written, never busy.
// PARAMETERS
//  PEND_W  2  width of per-register pending-write counter (max 2**PEND_W-1 writers in flight)
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset        in   1   synchronous, active-low reset (0 = reset)
//  i_pipe_stall   in   1   read stage holding; suppresses i_dprf_setbusy this cycle
//  i_pipe_flush   in   1   pipeline flush; clears scoreboard, suppresses i_dprf_setbusy
//  i_read_a1      in   4   read port 1 address
//  i_read_a2      in   4   read port 2 address
//  o_d1           out  32  read port 1 data (combinational)
//  o_d2           out  32  read port 2 data (combinational)
//  i_dprf_setbusy in   4   DR to mark pending; 0 = none
//  i_wb_reg       in   4   writeback register; 0 = no writeback
//  i_wb_data      in   32  writeback data
//  o_busylist     out  15  bit k-1 high = r(k) has >=1 pending write
//  o_sb_overflow  out  1   sticky: set issued to a saturated counter
// BEHAVIOUR
//  Reset (i_reset==0 at edge): r1..r15 <= 0, all counters <= 0, o_sb_overflow <= 0.
//   Write and set are ignored in the reset cycle.
//  Read: o_dN = 0 if addr==0.
//   Else if addr==i_wb_reg (nonzero): o_dN = i_wb_data (write-through, same cycle).
//   Else: o_dN = stored value. No cycle latency.
//  Write: at edge, if i_wb_reg!=0, r[i_wb_reg] <= i_wb_data. Writeback is never gated by stall/flush.
//  Scoreboard, per register k in 1..15, at edge:
//   set_k = (i_dprf_setbusy==k) && !i_pipe_stall && !i_pipe_flush.
//   clr_k = (i_wb_reg==k).
//   flush: cnt <= 0 (all regs), overrides set and clr.
//   set&clr same reg same cycle: cnt unchanged.
//   set only: cnt+1. If cnt==max, hold cnt and set o_sb_overflow.
//   clr only: cnt-1. If cnt==0, hold 0 (stray writeback tolerated, no flag).
//  o_busylist[k-1] = (cnt_k != 0). Registered view only; the same-cycle set is visible next cycle.
//  Writeback clearing the last pending write: bit drops the next cycle.
//   The read that same cycle already gets the data via write-through.
//  o_sb_overflow clears only on reset.
//  Reset asserted mid-operation: discards all pending counts; writeback data in that cycle is lost.
// STRUCTURE
//  tl45_pkg: localparam NUM_REGS=16, REG_AW=4, XLEN=32; typedef logic [REG_AW-1:0] reg_addr_t.
//  Sub-module tl45_busy_counter (PEND_W): inputs set, clr, flush; outputs busy, ovf.
//   Instantiated via generate for r1..r15.
//  Top: storage array, write-through read muxes, set/clr decode, overflow OR-reduce.
// TESTING
//  1 Reset: drive i_reset=0 one cycle; read a1=5, a2=15 -> o_d1=o_d2=0, o_busylist=0, ovf=0.
//  2 Write/read: wb r3=32'hDEADBEEF.
//    Same cycle a1=3 -> o_d1=DEADBEEF (bypass).
//    Next cycle, wb idle, a1=3 -> DEADBEEF. a2=0 -> 0 after wb r0=1234.
//  3 Scoreboard: setbusy=7 -> next cycle busylist[6]=1.
//    setbusy=7 again -> cnt 2. wb r7 -> still busy. wb r7 -> busylist[6]=0 next cycle.
//  4 Collision/gating: cnt r4=1.
//    setbusy=4 with wb r4 same cycle -> still busy, cnt=1.
//    setbusy=9 with i_pipe_stall=1 -> busylist[8] stays 0.
//  5 Flush/saturation (PEND_W=2): setbusy=2 x3 -> cnt 3, 4th set -> o_sb_overflow=1, cnt 3.
//    i_pipe_flush=1 with setbusy=5 -> busylist=0. Overflow stays 1 until reset.

Source files
------------

// File: rtl/tl45_pkg.sv
// Shared constants and types for the TL45 register-file slice.
package tl45_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int XLEN     = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   word_t;

endpackage

// File: rtl/tl45_dprf_if.sv
// Register-read / writeback / scoreboard signal bundle between the pipeline and tl45_dprf.
interface tl45_dprf_if;
    import tl45_pkg::*;

    logic                  i_pipe_stall;
    logic                  i_pipe_flush;
    reg_addr_t             i_read_a1;
    reg_addr_t             i_read_a2;
    word_t                 o_d1;
    word_t                 o_d2;
    reg_addr_t             i_dprf_setbusy;
    reg_addr_t             i_wb_reg;
    word_t                 i_wb_data;
    logic [NUM_REGS-2:0]   o_busylist;
    logic                  o_sb_overflow;

    modport master (
        output i_pipe_stall, i_pipe_flush, i_read_a1, i_read_a2,
               i_dprf_setbusy, i_wb_reg, i_wb_data,
        input  o_d1, o_d2, o_busylist, o_sb_overflow
    );

    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_read_a1, i_read_a2,
               i_dprf_setbusy, i_wb_reg, i_wb_data,
        output o_d1, o_d2, o_busylist, o_sb_overflow
    );

endinterface

// File: rtl/tl45_dprf_busy_counter.sv
// Saturating pending-write counter for one architectural register, with sticky overflow flag.
module tl45_busy_counter #(
    parameter int PEND_W = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic set_i,
    input  logic clr_i,
    input  logic flush_i,
    output logic busy_o,
    output logic ovf_o
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (set_i && !clr_i) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (clr_i && !set_i) begin
            // A writeback with nothing pending is a stray and is simply ignored.
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/tl45_dprf.sv
// TL45 dual-read, single-write register file with write-through reads and pending-write scoreboard.
module tl45_dprf
    import tl45_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    tl45_dprf_if.slave  bus
);

    word_t regs_q [1:NUM_REGS-1];
    word_t regs_d [1:NUM_REGS-1];

    logic [NUM_REGS-1:1] set_vec;
    logic [NUM_REGS-1:1] clr_vec;
    logic [NUM_REGS-1:1] busy_vec;
    logic [NUM_REGS-1:1] ovf_vec;
    logic                setbusy_ok;

    always_comb begin
        regs_d = regs_q;
        if (bus.i_wb_reg != '0) regs_d[bus.i_wb_reg] = bus.i_wb_data;
    end

    // NOTE: the whole array is cleared on reset because software may read any register right after it.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Writeback data is forwarded so the read stage sees it in the same cycle it is written.
    always_comb begin
        bus.o_d1 = '0;
        if (bus.i_read_a1 == '0)                bus.o_d1 = '0;
        else if (bus.i_read_a1 == bus.i_wb_reg) bus.o_d1 = bus.i_wb_data;
        else                                    bus.o_d1 = regs_q[bus.i_read_a1];
    end

    always_comb begin
        bus.o_d2 = '0;
        if (bus.i_read_a2 == '0)                bus.o_d2 = '0;
        else if (bus.i_read_a2 == bus.i_wb_reg) bus.o_d2 = bus.i_wb_data;
        else                                    bus.o_d2 = regs_q[bus.i_read_a2];
    end

    assign setbusy_ok = !bus.i_pipe_stall && !bus.i_pipe_flush;

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_sb
        assign set_vec[k] = setbusy_ok && (bus.i_dprf_setbusy == reg_addr_t'(k));
        assign clr_vec[k] = (bus.i_wb_reg == reg_addr_t'(k));

        tl45_busy_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .set_i   (set_vec[k]),
            .clr_i   (clr_vec[k]),
            .flush_i (bus.i_pipe_flush),
            .busy_o  (busy_vec[k]),
            .ovf_o   (ovf_vec[k])
        );
    end

    assign bus.o_busylist    = busy_vec;
    assign bus.o_sb_overflow = |ovf_vec;

endmodule
